// File: rtl/feature_loader.sv
// Burst loader: streams one or two feature-map patches from memory into the
// patch FIFOs, alternating bursts between patches when both are requested.
module feature_loader #(
  parameter int unsigned MEM_DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned BURST_LEN      = 16
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic                      load_begin,
  output logic                      load_finish,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH-1:0]     patch2_offset,
  input  logic [9:0]                row_size,
  input  logic [9:0]                col_size,
  input  logic                      double_patch,
  output logic                      mem_rd_req,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  output logic [7:0]                mem_rd_len,
  input  logic                      mem_rd_ack,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  input  logic                      mem_rd_data_valid,
  output logic [MEM_DATA_WIDTH-1:0] feature_data,
  output logic                      feature_buffer_1_valid,
  output logic                      feature_buffer_2_valid,
  input  logic                      feature_buffer_1_ready,
  input  logic                      feature_buffer_2_ready,
  output logic                      busy
);

  localparam int unsigned CNT_W      = $clog2(BURST_LEN + 1);
  localparam int unsigned BEAT_W     = 18;
  localparam int unsigned BEAT_BYTES = MEM_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, NEXT, DONE} state_e;

  state_e                    state_q, state_d;
  logic                      double_q, double_d;
  logic                      sel_q, sel_d;
  logic [BEAT_W-1:0]         rem1_q, rem1_d, rem2_q, rem2_d;
  logic [ADDR_WIDTH-1:0]     addr1_q, addr1_d, addr2_q, addr2_d;
  logic [CNT_W-1:0]          burst_q, burst_d, beat_cnt_q, beat_cnt_d;
  logic                      rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic [7:0]                rd_len_q, rd_len_d;
  logic                      fb1_q, fb1_d, fb2_q, fb2_d;
  logic                      finish_q, finish_d;
  logic                      busy_q, busy_d;
  logic [MEM_DATA_WIDTH-1:0] fdata_q, fdata_d;

  logic [19:0]               prod_c;
  logic [BEAT_W-1:0]         beats_c, rem_sel_c, rem_oth_c;
  logic [CNT_W-1:0]          burst_c;
  logic [ADDR_WIDTH-1:0]     step_c;

  // Beats per patch, the size of the next burst and the address step after it
  always_comb begin
    prod_c    = 20'(row_size) * 20'(col_size);
    beats_c   = BEAT_W'((21'(prod_c) + 21'd3) >> 2);
    rem_sel_c = sel_q ? rem2_q : rem1_q;
    rem_oth_c = sel_q ? rem1_q : rem2_q;
    burst_c   = (rem_sel_c < BEAT_W'(BURST_LEN)) ? CNT_W'(rem_sel_c) : CNT_W'(BURST_LEN);
    step_c    = ADDR_WIDTH'(burst_q) * ADDR_WIDTH'(BEAT_BYTES);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    double_d   = double_q;
    sel_d      = sel_q;
    rem1_d     = rem1_q;
    rem2_d     = rem2_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    fdata_d    = fdata_q;
    fb1_d      = 1'b0;
    fb2_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_begin) begin
          double_d = double_patch;
          sel_d    = 1'b0;
          rem1_d   = beats_c;
          rem2_d   = double_patch ? beats_c : '0;
          addr1_d  = base_addr;
          addr2_d  = base_addr + patch2_offset;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (rem1_q == '0 && rem2_q == '0) begin
          state_d = DONE;
        end else if (sel_q ? feature_buffer_2_ready : feature_buffer_1_ready) begin
          burst_d    = burst_c;
          beat_cnt_d = '0;
          rd_addr_d  = sel_q ? addr2_q : addr1_q;
          rd_len_d   = 8'(burst_c - CNT_W'(1));
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_rd_ack) state_d = DATA;
      end
      DATA: begin
        if (mem_rd_data_valid) begin
          fdata_d    = mem_rd_data;
          fb1_d      = ~sel_q;
          fb2_d      = sel_q;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == burst_q - CNT_W'(1)) state_d = NEXT;
        end
      end
      NEXT: begin
        if (sel_q) begin
          addr2_d = addr2_q + step_c;
          rem2_d  = rem2_q - BEAT_W'(burst_q);
        end else begin
          addr1_d = addr1_q + step_c;
          rem1_d  = rem1_q - BEAT_W'(burst_q);
        end
        if (double_q && rem_oth_c != '0) sel_d = ~sel_q;
        state_d = CHECK;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_req_d = (state_d == REQ);
    finish_d = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      double_q   <= 1'b0;
      sel_q      <= 1'b0;
      rem1_q     <= '0;
      rem2_q     <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      fb1_q      <= 1'b0;
      fb2_q      <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      fdata_q    <= '0;
    end else begin
      double_q   <= double_d;
      sel_q      <= sel_d;
      rem1_q     <= rem1_d;
      rem2_q     <= rem2_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      fb1_q      <= fb1_d;
      fb2_q      <= fb2_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
      fdata_q    <= fdata_d;
    end
  end

  assign mem_rd_req             = rd_req_q;
  assign mem_rd_addr            = rd_addr_q;
  assign mem_rd_len             = rd_len_q;
  assign feature_buffer_1_valid = fb1_q;
  assign feature_buffer_2_valid = fb2_q;
  assign feature_data           = fdata_q;
  assign load_finish            = finish_q;
  assign busy                   = busy_q;

endmodule

// File: tb/tb_feature_loader.sv
// Randomized bench for feature_loader with a burst-list reference model and a
// memory responder that checks requests and every forwarded beat.
module tb_feature_loader;

  localparam int unsigned DW    = 512;
  localparam int unsigned AW    = 32;
  localparam int unsigned BL    = 16;
  localparam int unsigned BYTES = DW / 8;

  logic          system_clk = 1'b0;
  logic          rst_n;
  logic          load_begin, load_finish;
  logic [AW-1:0] base_addr, patch2_offset;
  logic [9:0]    row_size, col_size;
  logic          double_patch;
  logic          mem_rd_req, mem_rd_ack;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_len;
  logic [DW-1:0] mem_rd_data, feature_data;
  logic          mem_rd_data_valid;
  logic          feature_buffer_1_valid, feature_buffer_2_valid;
  logic          feature_buffer_1_ready, feature_buffer_2_ready;
  logic          busy;

  feature_loader #(.MEM_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .system_clk(system_clk), .rst_n(rst_n), .load_begin(load_begin), .load_finish(load_finish),
    .base_addr(base_addr), .patch2_offset(patch2_offset), .row_size(row_size), .col_size(col_size),
    .double_patch(double_patch), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_len(mem_rd_len), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid), .feature_data(feature_data),
    .feature_buffer_1_valid(feature_buffer_1_valid), .feature_buffer_2_valid(feature_buffer_2_valid),
    .feature_buffer_1_ready(feature_buffer_1_ready), .feature_buffer_2_ready(feature_buffer_2_ready),
    .busy(busy)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    int            patch;
  } burst_t;

  burst_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Expected burst sequence: each patch cut into BL-beat chunks, then merged
  // alternately starting with patch 1.
  function automatic void build_bursts(input int rows, input int cols, input bit dbl,
                                       input logic [AW-1:0] base, input logic [AW-1:0] off);
    burst_t l1[$];
    burst_t l2[$];
    int     beats;
    beats = (rows * cols + 3) / 4;
    for (int p = 0; p < (dbl ? 2 : 1); p++) begin
      int            left;
      logic [AW-1:0] a;
      left = beats;
      a    = (p == 1) ? base + off : base;
      while (left > 0) begin
        int     n;
        burst_t b;
        n       = (left > int'(BL)) ? int'(BL) : left;
        b.addr  = a;
        b.len   = n - 1;
        b.patch = p;
        if (p == 1) l2.push_back(b);
        else        l1.push_back(b);
        a    = a + AW'(n * int'(BYTES));
        left = left - n;
      end
    end
    exp_q.delete();
    while (l1.size() > 0 || l2.size() > 0) begin
      if (l1.size() > 0) exp_q.push_back(l1.pop_front());
      if (l2.size() > 0) exp_q.push_back(l2.pop_front());
    end
  endfunction

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_ctrl"}, DW'({mem_rd_req, feature_buffer_1_valid, feature_buffer_2_valid,
                                  load_finish, busy}), '0);
    check({tag, "_rst_data"}, feature_data, '0);
    @(negedge system_clk);
    rst_n = 1'b1;
  endtask

  task automatic run_load(input string name, input int rows, input int cols, input bit dbl,
                          input logic [AW-1:0] base, input logic [AW-1:0] off,
                          input bit gap, input int abort_at);
    int            cyc, left, sent, gap_cnt, rise_cyc, cnt1, cnt2, fin_cyc, beats;
    bit            finished, delivering, have_burst, pend_v, pend_p, cur_p, gap_done, wait_rise;
    logic [DW-1:0] pend_d, d;
    burst_t        b;
    build_bursts(rows, cols, dbl, base, off);
    beats = (rows * cols + 3) / 4;
    {finished, delivering, have_burst, pend_v, pend_p, cur_p, gap_done, wait_rise} = '0;
    {left, sent, gap_cnt, rise_cyc, cnt1, cnt2, fin_cyc} = '0;
    pend_d = '0;
    @(negedge system_clk);
    row_size = 10'(rows); col_size = 10'(cols); double_patch = dbl;
    base_addr = base; patch2_offset = off;
    feature_buffer_1_ready = 1'b1; feature_buffer_2_ready = 1'b1;
    load_begin = 1'b1;
    @(negedge system_clk);
    load_begin = 1'b0;
    for (cyc = 1; cyc <= 6000; cyc++) begin
      check({name, "_strobe"}, DW'({feature_buffer_2_valid, feature_buffer_1_valid}),
            DW'({pend_v & pend_p, pend_v & ~pend_p}));
      if (pend_v) check({name, "_data"}, feature_data, pend_d);
      cnt1 += int'(feature_buffer_1_valid);
      cnt2 += int'(feature_buffer_2_valid);
      if (cyc == 1) check({name, "_busy_start"}, DW'(busy), 1);
      if (load_finish) begin
        finished = 1'b1;
        fin_cyc  = cyc;
      end
      mem_rd_ack = 1'b0; mem_rd_data_valid = 1'b0; pend_v = 1'b0;
      if (finished) break;
      if (abort_at > 0 && sent >= abort_at) begin
        do_reset({name, "_abort"});
        for (int i = 0; i < 6; i++) begin
          mem_rd_data_valid = 1'b1;
          mem_rd_data       = rand_beat();
          @(negedge system_clk);
          check({name, "_stray"}, DW'({feature_buffer_1_valid, feature_buffer_2_valid,
                                       mem_rd_req, busy, load_finish}), '0);
        end
        mem_rd_data_valid = 1'b0;
        return;
      end
      if (gap_cnt > 0) begin
        gap_cnt--;
        if (gap_cnt == 0) begin
          feature_buffer_1_ready = 1'b1; feature_buffer_2_ready = 1'b1;
          rise_cyc = cyc; wait_rise = 1'b1;
        end
      end
      if (delivering) begin
        if ($urandom_range(0, 9) < 7) begin
          d = rand_beat();
          mem_rd_data_valid = 1'b1; mem_rd_data = d;
          pend_v = 1'b1; pend_p = cur_p; pend_d = d;
          left--; sent++;
          if (left == 0) begin
            delivering = 1'b0;
            if (gap && !gap_done) begin
              feature_buffer_1_ready = 1'b0; feature_buffer_2_ready = 1'b0;
              gap_cnt = 50; gap_done = 1'b1;
            end
          end
        end else begin
          mem_rd_data_valid = $urandom_range(0, 1) == 1;
          mem_rd_data       = rand_beat();
          mem_rd_data_valid = 1'b0;
        end
      end else if (mem_rd_req) begin
        if (gap_cnt > 0) check({name, "_req_not_ready"}, 1, 0);
        if (wait_rise) begin
          check({name, "_ready_latency"}, DW'((cyc - rise_cyc) <= 2), 1);
          wait_rise = 1'b0;
        end
        if (!have_burst) begin
          if (exp_q.size() == 0) begin
            check({name, "_unexpected_req"}, 1, 0);
            break;
          end
          b = exp_q.pop_front();
          check({name, "_addr"}, DW'(mem_rd_addr), DW'(b.addr));
          check({name, "_len"}, DW'(mem_rd_len), DW'(b.len));
          cur_p = b.patch[0]; have_burst = 1'b1;
        end
        if ($urandom_range(0, 1) == 1) begin
          mem_rd_ack = 1'b1; delivering = 1'b1; left = b.len + 1; have_burst = 1'b0;
        end
      end
      @(negedge system_clk);
    end
    check({name, "_finished"}, DW'(finished), 1);
    check({name, "_bursts_left"}, DW'(exp_q.size()), 0);
    check({name, "_cnt1"}, DW'(cnt1), DW'(beats));
    check({name, "_cnt2"}, DW'(cnt2), DW'(dbl ? beats : 0));
    if (beats == 0) check({name, "_empty_latency"}, DW'(fin_cyc), 2);
    @(negedge system_clk);
    check({name, "_after"}, DW'({feature_buffer_1_valid, feature_buffer_2_valid, load_finish,
                                busy, mem_rd_req}), '0);
  endtask

  initial begin
    rst_n = 1'b0; load_begin = 1'b0; base_addr = '0; patch2_offset = '0;
    row_size = '0; col_size = '0; double_patch = 1'b0; mem_rd_ack = 1'b0;
    mem_rd_data = '0; mem_rd_data_valid = 1'b0;
    feature_buffer_1_ready = 1'b1; feature_buffer_2_ready = 1'b1;
    @(negedge system_clk);
    do_reset("init");
    run_load("single8x8", 8, 8, 1'b0, 32'h1000, 32'h0, 1'b0, 0);
    run_load("double8x8", 8, 8, 1'b1, 32'h1000, 32'h10000, 1'b0, 0);
    run_load("gap10x10", 10, 10, 1'b0, 32'h1000, 32'h0, 1'b1, 0);
    run_load("empty0x5", 0, 5, 1'b0, 32'h1000, 32'h0, 1'b0, 0);
    run_load("abort", 10, 10, 1'b1, 32'h2000, 32'h8000, 1'b0, 5);
    run_load("post_abort", 8, 8, 1'b0, 32'h1000, 32'h0, 1'b0, 0);
    run_load("wrap", 9, 7, 1'b1, 32'hFFFF_FF00, 32'hFFFF_F000, 1'b0, 0);
    for (int t = 0; t < 5; t++) begin
      run_load($sformatf("rand%0d", t), int'($urandom_range(0, 40)), int'($urandom_range(1, 40)),
               $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/feature_loader.md
FEATURE_LOADER -- requirements
Module: feature_loader

Interface
REQ-001 Parameters: MEM_DATA_WIDTH, default 512, memory beat width (4 pixels x 8 channels x 16 bit); ADDR_WIDTH, default 32, byte address width; BURST_LEN, default 16, maximum beats per read burst.
REQ-002 system_clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 load_begin  in  1  single-cycle start pulse.
REQ-005 load_finish  out  1  single-cycle pulse when the last beat is forwarded.
REQ-006 base_addr  in  ADDR_WIDTH  patch-1 start address, sampled at load_begin.
REQ-007 patch2_offset  in  ADDR_WIDTH  patch-2 address = base_addr + patch2_offset, sampled at load_begin.
REQ-008 row_size, col_size  in  10 each  feature map rows/cols, sampled at load_begin.
REQ-009 double_patch  in  1  1 = load patch 1 and patch 2 (16 channels), 0 = patch 1 only, sampled at load_begin.
REQ-010 mem_rd_req  out  1  read request, held until mem_rd_ack.
REQ-011 mem_rd_addr  out  ADDR_WIDTH  burst start byte address.
REQ-012 mem_rd_len  out  8  burst length in beats, minus 1.
REQ-013 mem_rd_ack  in  1  request accepted.
REQ-014 mem_rd_data  in  MEM_DATA_WIDTH  read beat; mem_rd_data_valid  in  1  beat qualifier.
REQ-015 feature_data  out  MEM_DATA_WIDTH  beat forwarded to the feature buffer.
REQ-016 feature_buffer_1_valid, feature_buffer_2_valid  out  1 each  write strobe to patch-1/patch-2 FIFOs.
REQ-017 feature_buffer_1_ready, feature_buffer_2_ready  in  1 each  high = target FIFOs can absorb at least BURST_LEN beats.
REQ-018 busy  out  1  high from the cycle after an accepted load_begin until load_finish.

Function
REQ-019 Beats per patch: total = ceil(row_size*col_size/4), 20-bit product, 18-bit beat count.
REQ-020 FSM states: IDLE, CHECK, REQ, DATA, NEXT, DONE.
REQ-021 IDLE: load_begin registers all inputs -> CHECK; load_begin in any other state is ignored.
REQ-022 CHECK: remaining beats of both active patches == 0 -> DONE; else, if the selected patch's ready == 1 -> REQ; else stay.
REQ-023 REQ: mem_rd_req = 1, addr = patch address pointer, len = min(BURST_LEN, remaining) - 1; on mem_rd_ack -> DATA.
REQ-024 DATA: each mem_rd_data_valid beat is registered to feature_data with the selected patch strobe one cycle later (latency 1); after len+1 beats -> NEXT.
REQ-025 NEXT: advance the selected patch's address by beats*MEM_DATA_WIDTH/8 and decrement its remaining count; double_patch = 1 toggles the patch selection only if the other patch still has beats; -> CHECK.
REQ-026 Patch order with double_patch = 1: alternate bursts, patch 1 first; double_patch = 0: patch 2 is never selected, feature_buffer_2_valid is never asserted.
REQ-027 DONE: load_finish = 1 for one cycle, coincident with or after the final strobe; -> IDLE.
REQ-028 mem_rd_data_valid outside DATA is ignored; no strobe is asserted.
REQ-029 At most one of feature_buffer_1_valid/feature_buffer_2_valid is high in any cycle.
REQ-030 Address arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-031 row_size*col_size == 0: no memory request; load_finish 2 cycles after load_begin.
REQ-032 Non-multiple-of-4 pixel count: the final beat is forwarded whole; padding lanes are don't-care.

Reset
REQ-033 Asserting rst_n low at any time: FSM -> IDLE, outputs mem_rd_req, feature_buffer_1_valid, feature_buffer_2_valid, load_finish and busy = 0, feature_data = 0, counters and pointers = 0.
REQ-034 Reset mid-burst abandons the burst; beats arriving after reset release are ignored until the next load_begin.

Verification
REQ-035 8x8, double_patch = 0, base 0x1000, ready high -> one burst, addr 0x1000, len 15, 16 patch-1 strobes, load_finish after the 16th.
REQ-036 8x8, double_patch = 1, offset 0x10000 -> bursts at 0x1000, 0x11000 alternately, 16 strobes each, no overlap of the two strobes.
REQ-037 10x10 (100 px = 25 beats), double_patch = 0 -> bursts len 15 then len 8, second addr 0x1400.
REQ-038 feature_buffer_1_ready low 50 cycles between bursts -> no mem_rd_req while low; request issued within 2 cycles of ready rising.
REQ-039 0x5 map -> no mem_rd_req, load_finish exactly 2 cycles after load_begin.
REQ-040 rst_n pulsed low mid-DATA, then stray mem_rd_data_valid beats -> all outputs 0, no strobes; a new load_begin completes normally.
